alu_share_arbiter: RTL and testbench

//  Shares one ALU datapath instance between two requesters (port 0 and port 1).

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_share_arbiter_alu.sv | 33 +++
 rtl/alu_share_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU share arbiter: ALU control codes,
// datapath widths and the arbiter FSM state encoding.
package alu_pkg;

    localparam int ALU_W       = 32;
    localparam int ALU_SHAMT_W = 6;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// ALU datapath: ADD/SUB/AND/OR/SLT/SLL, unlisted codes give zero.
// Ports: a_i, b_i operands; shamt_i shift amount; alu_con_i control;
//        s_o result; zero_o set when the result is zero.
module alu_share_arbiter_alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0]       a_i,
    input  logic [ALU_W-1:0]       b_i,
    input  logic [ALU_SHAMT_W-1:0] shamt_i,
    input  logic [3:0]             alu_con_i,
    output logic [ALU_W-1:0]       s_o,
    output logic                   zero_o
);

    localparam logic [ALU_W-2:0] PAD = '0;

    always_comb begin
        s_o = '0;
        unique case (alu_con_i)
            ALU_ADD: s_o = a_i + b_i;
            ALU_SUB: s_o = a_i - b_i;
            // AND/OR act on operand truth values, not bitwise.
            ALU_AND: s_o = {PAD, (|a_i) && (|b_i)};
            ALU_OR:  s_o = {PAD, (|a_i) || (|b_i)};
            ALU_SLT: s_o = {PAD, a_i < b_i};
            ALU_SLL: s_o = b_i << shamt_i;
            default: s_o = '0;
        endcase
    end

    assign zero_o = (s_o == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Arbitrates two requesters onto one ALU; one operation in flight.
// Ports: clk, rst (async high); reqN_* request channels; rspN_* responses.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int FAIR    = 1,
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_a,
    input  logic [DATA_W-1:0]  req0_b,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [3:0]         req0_alu_con,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_a,
    input  logic [DATA_W-1:0]  req1_b,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic [3:0]         req1_alu_con,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [DATA_W-1:0]  rsp0_s,
    output logic               rsp0_zero,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [DATA_W-1:0]  rsp1_s,
    output logic               rsp1_zero
);

    state_e             state_q, state_d;
    logic               last_grant_q;
    logic               gid_q;
    logic [DATA_W-1:0]  a_q, b_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic [3:0]         con_q;
    logic               rsp0_valid_q, rsp1_valid_q;
    logic [DATA_W-1:0]  rsp0_s_q, rsp1_s_q;
    logic               rsp0_zero_q, rsp1_zero_q;

    logic               gnt;
    logic               accept, exec, done;
    logic [DATA_W-1:0]  alu_s;
    logic               alu_zero;

    // gnt: 1 selects port 1. On a tie, round-robin avoids last winner.
    always_comb begin
        gnt = req1_valid;
        if (req0_valid && req1_valid) begin
            gnt = (FAIR != 0) ? ~last_grant_q : 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        exec       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready = ~gnt;
                    req1_ready = gnt;
                    accept     = 1'b1;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                exec    = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (gid_q ? rsp1_ready : rsp0_ready) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            gid_q        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            shamt_q      <= '0;
            con_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_s_q     <= '0;
            rsp1_s_q     <= '0;
            rsp0_zero_q  <= 1'b0;
            rsp1_zero_q  <= 1'b0;
        end else begin
            if (accept) begin
                gid_q   <= gnt;
                a_q     <= gnt ? req1_a       : req0_a;
                b_q     <= gnt ? req1_b       : req0_b;
                shamt_q <= gnt ? req1_shamt   : req0_shamt;
                con_q   <= gnt ? req1_alu_con : req0_alu_con;
            end
            if (exec) begin
                if (gid_q) begin
                    rsp1_s_q     <= alu_s;
                    rsp1_zero_q  <= alu_zero;
                    rsp1_valid_q <= 1'b1;
                end else begin
                    rsp0_s_q     <= alu_s;
                    rsp0_zero_q  <= alu_zero;
                    rsp0_valid_q <= 1'b1;
                end
            end
            if (done) begin
                rsp0_valid_q <= 1'b0;
                rsp1_valid_q <= 1'b0;
                last_grant_q <= gid_q;
            end
        end
    end

    alu_share_arbiter_alu u_alu (
        .a_i       (a_q),
        .b_i       (b_q),
        .shamt_i   (shamt_q),
        .alu_con_i (con_q),
        .s_o       (alu_s),
        .zero_o    (alu_zero)
    );

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_s     = rsp0_s_q;
    assign rsp1_s     = rsp1_s_q;
    assign rsp0_zero  = rsp0_zero_q;
    assign rsp1_zero  = rsp1_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: instance 1 uses FAIR=1, instance 0 FAIR=0.
// A transaction-level model is compared against both every cycle.
module tb_alu_share_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Arrays are indexed [instance][port]; instance index equals FAIR.
    logic        vld [2][2];
    logic        rdy [2][2];
    logic [31:0] opa [2][2];
    logic [31:0] opb [2][2];
    logic [5:0]  sh  [2][2];
    logic [3:0]  con [2][2];
    logic        rv  [2][2];
    logic        rr  [2][2];
    logic [31:0] rs  [2][2];
    logic        rz  [2][2];

    int npass = 0;
    int nchk  = 0;

    alu_share_arbiter #(.FAIR(1)) u_fair (
        .clk(clk), .rst(rst),
        .req0_valid(vld[1][0]), .req0_ready(rdy[1][0]),
        .req0_a(opa[1][0]), .req0_b(opb[1][0]),
        .req0_shamt(sh[1][0]), .req0_alu_con(con[1][0]),
        .req1_valid(vld[1][1]), .req1_ready(rdy[1][1]),
        .req1_a(opa[1][1]), .req1_b(opb[1][1]),
        .req1_shamt(sh[1][1]), .req1_alu_con(con[1][1]),
        .rsp0_valid(rv[1][0]), .rsp0_ready(rr[1][0]),
        .rsp0_s(rs[1][0]), .rsp0_zero(rz[1][0]),
        .rsp1_valid(rv[1][1]), .rsp1_ready(rr[1][1]),
        .rsp1_s(rs[1][1]), .rsp1_zero(rz[1][1])
    );

    alu_share_arbiter #(.FAIR(0)) u_fix (
        .clk(clk), .rst(rst),
        .req0_valid(vld[0][0]), .req0_ready(rdy[0][0]),
        .req0_a(opa[0][0]), .req0_b(opb[0][0]),
        .req0_shamt(sh[0][0]), .req0_alu_con(con[0][0]),
        .req1_valid(vld[0][1]), .req1_ready(rdy[0][1]),
        .req1_a(opa[0][1]), .req1_b(opb[0][1]),
        .req1_shamt(sh[0][1]), .req1_alu_con(con[0][1]),
        .rsp0_valid(rv[0][0]), .rsp0_ready(rr[0][0]),
        .rsp0_s(rs[0][0]), .rsp0_zero(rz[0][0]),
        .rsp1_valid(rv[0][1]), .rsp1_ready(rr[0][1]),
        .rsp1_s(rs[0][1]), .rsp1_zero(rz[0][1])
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    // Reference ALU written directly from the operation definitions.
    function automatic logic [31:0] ref_alu(input logic [3:0] c,
        input logic [31:0] x, input logic [31:0] y, input logic [5:0] n);
        case (c)
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0000: return (x != 0 && y != 0) ? 32'd1 : 32'd0;
            4'b0001: return (x != 0 || y != 0) ? 32'd1 : 32'd0;
            4'b0111: return (x < y) ? 32'd1 : 32'd0;
            4'b1111: return y << n;
            default: return 32'd0;
        endcase
    endfunction

    // Model: one operation in flight; age counts edges since acceptance.
    bit          m_busy [2] = '{0, 0};
    int          m_age  [2] = '{0, 0};
    int          m_gid  [2] = '{0, 0};
    int          m_last [2] = '{1, 1};
    logic [31:0] m_s    [2];
    logic        m_z    [2];
    int          gq0[$];
    int          gq1[$];

    function automatic int pick(input int d);
        if (vld[d][0] && vld[d][1]) return (d == 1) ? 1 - m_last[d] : 0;
        return vld[d][1] ? 1 : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] = 0;
                m_age[d]  = 0;
                m_last[d] = 1;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!m_busy[d]) begin
                    if (vld[d][0] || vld[d][1]) begin
                        int g;
                        g = pick(d);
                        m_busy[d] = 1;
                        m_age[d]  = 0;
                        m_gid[d]  = g;
                        m_s[d] = ref_alu(con[d][g], opa[d][g], opb[d][g], sh[d][g]);
                        m_z[d] = (m_s[d] == 0);
                    end
                end else if (m_age[d] == 0) begin
                    m_age[d] = 1;
                end else if (rr[d][m_gid[d]]) begin
                    m_busy[d] = 0;
                    m_last[d] = m_gid[d];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                logic er, ev;
                er = !rst && !m_busy[d] && vld[d][p] && (pick(d) == p);
                ev = !rst && m_busy[d] && (m_age[d] == 1) && (m_gid[d] == p);
                chk($sformatf("d%0d_p%0d_ready", d, p), rdy[d][p], er);
                chk($sformatf("d%0d_p%0d_rvalid", d, p), rv[d][p], ev);
                if (ev) begin
                    chk($sformatf("d%0d_p%0d_s", d, p), rs[d][p], m_s[d]);
                    chk($sformatf("d%0d_p%0d_zero", d, p), rz[d][p], m_z[d]);
                end
                if (rst) begin
                    chk($sformatf("d%0d_p%0d_rst_s", d, p), rs[d][p], 0);
                    chk($sformatf("d%0d_p%0d_rst_z", d, p), rz[d][p], 0);
                end
                if (!rst && rdy[d][p] && vld[d][p]) begin
                    if (d == 1) gq1.push_back(p);
                    else        gq0.push_back(p);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Issue one op, check literal result and the accept->valid latency.
    task automatic op(input int d, input int p, input logic [3:0] c,
        input logic [31:0] x, input logic [31:0] y, input logic [5:0] n,
        input logic [31:0] es, input logic ez, input string nm);
        int k;
        con[d][p] = c; opa[d][p] = x; opb[d][p] = y; sh[d][p] = n;
        vld[d][p] = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rdy[d][p] && k < 20);
        if (!rdy[d][p]) begin
            chk({nm, "_accept_timeout"}, 0, 1);
            vld[d][p] = 1'b0;
            return;
        end
        step();
        vld[d][p] = 1'b0;
        @(negedge clk);
        chk({nm, "_lat_early"}, rv[d][p], 0);
        @(negedge clk);
        chk({nm, "_valid"}, rv[d][p], 1);
        chk({nm, "_s"}, rs[d][p], es);
        chk({nm, "_zero"}, rz[d][p], ez);
        chk({nm, "_other"}, rv[d][1-p], 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                vld[d][p] = 0; opa[d][p] = 0; opb[d][p] = 0;
                sh[d][p] = 0; con[d][p] = 0; rr[d][p] = 1;
            end
        end
        // 1: reset, idle, reset again mid-idle
        repeat (3) @(negedge clk);
        chk("t1_rst_valid", rv[1][0], 0);
        chk("t1_rst_s", rs[1][0], 0);
        step(); rst = 1'b0;
        repeat (4) @(negedge clk);
        step(); rst = 1'b1;
        @(negedge clk);
        chk("t1_rst2_ready", rdy[1][1], 0);
        step(); rst = 1'b0;
        // 2, 3: single ops
        step();
        op(1, 0, 4'b0010, 5, 7, 0, 12, 0, "t2_add");
        step();
        op(1, 1, 4'b0110, 9, 9, 0, 0, 1, "t3_sub");
        step();
        op(1, 1, 4'b1111, 0, 1, 4, 16, 0, "t3_sll");
        step();
        op(1, 0, 4'b0000, 3, 0, 0, 0, 1, "and_log");
        step();
        op(1, 0, 4'b0001, 0, 5, 0, 1, 0, "or_log");
        step();
        op(1, 1, 4'b0111, 2, 32'hFFFF_FFFF, 0, 1, 0, "slt_u");
        step();
        op(0, 1, 4'b0010, 32'hFFFF_FFFF, 1, 0, 0, 1, "fix_add_wrap");
        // 5: response backpressure
        step();
        rr[1][0] = 0;
        op(1, 0, 4'b0010, 1, 2, 0, 3, 0, "t5_add");
        step();
        con[1][1] = 4'b0110; opa[1][1] = 10; opb[1][1] = 3; vld[1][1] = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", rv[1][0], 1);
            chk("t5_hold_s", rs[1][0], 3);
            chk("t5_no_ready1", rdy[1][1], 0);
        end
        step();
        rr[1][0] = 1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_resume", rdy[1][1], 1);
        step();
        vld[1][1] = 0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_next_s", rs[1][1], 7);
        // 4: fairness vs fixed priority under continuous requests
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        gq0.delete();
        gq1.delete();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                con[d][p] = 4'b0010; opa[d][p] = p + 1; opb[d][p] = 10;
                vld[d][p] = 1;
            end
        end
        repeat (14) @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) vld[d][p] = 0;
        end
        repeat (6) @(negedge clk);
        chk("t4_fair_count", gq1.size() >= 4, 1);
        chk("t4_fix_count", gq0.size() >= 3, 1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t4_fair_g%0d", i),
                gq1.size() > i ? gq1[i] : 99, i % 2);
        for (int i = 0; i < 3; i++)
            chk($sformatf("t4_fix_g%0d", i), gq0.size() > i ? gq0[i] : 99, 0);
        // 6: reset during EXEC and during RESP drops the operation
        step();
        con[1][0] = 4'b0010; opa[1][0] = 4; opb[1][0] = 4; vld[1][0] = 1;
        @(negedge clk);
        chk("t6_acc1", rdy[1][0], 1);
        step(); rst = 1'b1; vld[1][0] = 0;
        @(negedge clk);
        step(); rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_no_rsp1", rv[1][0], 0);
        step();
        rr[1][0] = 0; vld[1][0] = 1;
        @(negedge clk);
        chk("t6_acc2", rdy[1][0], 1);
        step(); vld[1][0] = 0;
        step();
        @(negedge clk);
        chk("t6_in_resp", rv[1][0], 1);
        step(); rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_drop", rv[1][0], 0);
        step(); rst = 1'b0; rr[1][0] = 1;
        vld[1][0] = 1; vld[1][1] = 1;
        @(negedge clk);
        chk("t6_tie_p0", rdy[1][0], 1);
        chk("t6_tie_p1", rdy[1][1], 0);
        step(); vld[1][0] = 0; vld[1][1] = 0;
        repeat (6) @(negedge clk);
        step();
        op(1, 0, 4'b0011, 5, 6, 0, 0, 1, "t6_bad_con");
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
